relu_quant_stage: RTL and testbench
===================================

// Module: relu_quant_stage
// PURPOSE
//  Requantisation stage directly upstream of the pooling stage. Takes one column of LANES signed
//  conv accumulators per cycle and applies bias, multiply, arithmetic shift, ReLU and unsigned-8
//  saturation. Emits an unbroken valid burst of col beats per row, which the pooling stage requires.
//  Pulses row_end on the last beat of each row.
// PARAMETERS
//  LANES   24  output rows per column (pool input width = LANES*8)
//  ACC_W   32  signed accumulator width per lane
//  MULT_W  16  unsigned requant multiplier width
//  SHIFT_W  5  right-shift amount width (0..31)
// PORTS
//  clk       in   1             clock, all logic on rising edge
//  rst_n     in   1             reset, asynchronous, active-low
//  cfg_load  in   1             capture bias_in/mult_in/shift_in
//  bias_in   in   LANES*ACC_W   signed per-lane bias, lane i at [ACC_W*i +: ACC_W]
//  mult_in   in   MULT_W        unsigned multiplier, shared by all lanes
//  shift_in  in   SHIFT_W       right-shift amount, shared
//  col       in   16            beats per row; static while a row is in flight
//  valid_in  in   1             data_in valid, one column per beat
//  data_in   in   LANES*ACC_W   signed accumulators, lane i at [ACC_W*i +: ACC_W]
//  clr_err   in   1             clears sticky error flags
//  valid_out out  1             data_out valid
//  data_out  out  LANES*8       unsigned 8-bit results, lane i at [8*i +: 8]
//  row_end   out  1             one-cycle pulse, coincident with the last beat of a row
//  gap_err   out  1             sticky: valid_out dropped mid-row
//  cfg_err   out  1             sticky: cfg_load arrived while busy
// BEHAVIOUR
//  - Reset: all pipeline registers, config registers, the beat counter and every output = 0.
//    Reset mid-row aborts the row; no row_end is issued.
//  - Pipeline is fixed 3 cycles, no backpressure. valid_in at cycle t gives valid_out at t+3.
//    S1: s = acc + bias, ACC_W+1 bits signed.
//    S2: p = s * mult, ACC_W+1+MULT_W bits signed; mult is zero-extended.
//    S3: q = p >>> shift; if q<0 then 0; else if q>255 then 255; else q[7:0].
//  - Config: cfg_load takes effect only when idle (S1..S3 empty, beat counter = 0).
//    When idle, registers are updated on that edge and the next valid_in uses the new values.
//    When not idle, cfg_load is ignored and cfg_err is set.
//  - Beat counter (16b) counts valid_out beats.
//    When count == col-1: assert row_end with that beat and reset count to 0.
//    Otherwise: count+1.
//  - col==0: data still flows, row_end is never asserted, count saturates at 16'hFFFF.
//  - valid_out low while count != 0: set gap_err, reset count to 0. The partial row gets no row_end.
//  - clr_err clears both flags. If an error event occurs in the same cycle, the error wins (flag stays 1).
//  - Back-to-back rows are allowed; the first beat of the next row may directly follow a row_end beat.
// CONFIGURATION
//  REQUANT_ROUND_EN defined: S3 adds 1<<(shift-1) before the shift when shift>0 (round half up).
//  Not defined: plain truncating arithmetic shift. Latency is 3 cycles either way.
// STRUCTURE
//  Package qnt_pkg holds:
//   - width localparams: LANES, ACC_W, MULT_W, SHIFT_W, OUT_W=8
//   - function sat_u8(signed q) for the ReLU and clamp
//  Sub-module quant_lane is the 3-stage single-lane datapath, instantiated LANES times via generate.
//  The top level owns the valid pipe, config registers, beat counter and error flags.
// TESTING
//  1 Basic: bias 0, mult 1, shift 0, acc lanes = {0,1,..,23}, col 4 -> data_out equals lanes, latency 3,
//    row_end on beat 4 only.
//  2 Clamp/ReLU: acc -5 -> 0; acc 300 -> 255; acc 0x7FFFFFFF, mult 0xFFFF, shift 31 -> 255 (no wrap).
//  3 Bias+scale: acc 100, bias -20, mult 3, shift 2 -> 60. With acc 101: 60 truncating, 61 with REQUANT_ROUND_EN.
//  4 Rows: col 6, 12 continuous beats -> 2 row_end pulses at beats 6 and 12, gap_err stays 0.
//  5 Gap: col 6, valid low after 3 beats -> gap_err=1, no row_end; next full row of 6 -> row_end ok;
//    clr_err -> 0.
//  6 Config/reset: cfg_load mid-row -> cfg_err=1, outputs use old mult. rst_n low mid-row ->
//    all outputs 0 immediately (async), counter 0.

Source files
------------

// File: rtl/qnt_pkg.sv
// Shared widths and the ReLU/u8 clamp for the requantisation stage.
package qnt_pkg;
   localparam int LANES   = 24;
   localparam int ACC_W   = 32;
   localparam int MULT_W  = 16;
   localparam int SHIFT_W = 5;
   localparam int OUT_W   = 8;
   localparam int CNT_W   = 16;
   localparam int STAGES  = 3;
   localparam int SUM_W   = ACC_W + 1;       // acc + bias
   localparam int PROD_W  = SUM_W + MULT_W;  // sum * zero-extended mult
   localparam int RND_W   = PROD_W + 1;      // headroom for the rounding add

   // ReLU then clamp to 0..255
   function automatic logic [OUT_W-1:0] sat_u8(input logic signed [RND_W-1:0] q);
      logic [OUT_W-1:0] r;
      if (q[RND_W-1])                    r = '0;
      else if (q[RND_W-2:OUT_W] != '0)   r = '1;
      else                               r = q[OUT_W-1:0];
      return r;
   endfunction
endpackage

// File: rtl/relu_quant_stage_if.sv
// Column stream into the stage and the requantised stream out to pooling.
interface relu_quant_stage_if;
   import qnt_pkg::*;
   logic                              valid_in;
   logic [LANES-1:0][ACC_W-1:0]       data_in;
   logic                              valid_out;
   logic [LANES-1:0][OUT_W-1:0]       data_out;
   logic                              row_end;

   modport master (output valid_in, data_in, input valid_out, data_out, row_end);
   modport slave  (input valid_in, data_in, output valid_out, data_out, row_end);
endinterface

// File: rtl/quant_lane.sv
// One lane of the 3-stage requant datapath: bias add, scale, shift + clamp.
// REQUANT_ROUND_EN: add half an LSB before the shift (round half up).
module quant_lane
   import qnt_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [STAGES-1:0]        en,
   input  logic signed [ACC_W-1:0]  acc,
   input  logic signed [ACC_W-1:0]  bias,
   input  logic [MULT_W-1:0]        mult,
   input  logic [SHIFT_W-1:0]       shift,
   output logic [OUT_W-1:0]         q_out
);
   logic signed [SUM_W-1:0]  s1;
   logic signed [PROD_W-1:0] p2, s_ext, m_ext;
   logic signed [RND_W-1:0]  p_ext, rnd, q;

   assign s_ext = PROD_W'(s1);
   assign m_ext = PROD_W'({1'b0, mult});

   // S3 shift amount, optional rounding offset
   always_comb begin
      p_ext = RND_W'(p2);
      rnd   = '0;
`ifdef REQUANT_ROUND_EN
      if (shift != '0) rnd = RND_W'(1) << (shift - 1'b1);
`endif
      q = (p_ext + rnd) >>> shift;
   end

   // stage registers, each advancing only when its input beat is valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1    <= '0;
         p2    <= '0;
         q_out <= '0;
      end else begin
         if (en[0]) s1    <= SUM_W'(acc) + SUM_W'(bias);
         if (en[1]) p2    <= s_ext * m_ext;
         if (en[2]) q_out <= sat_u8(q);
      end
   end
endmodule

// File: rtl/relu_quant_stage.sv
// Requant stage top: valid pipe, config capture, row beat counter, sticky errors.
// Optional macro REQUANT_ROUND_EN selects round-half-up in the lanes.
module relu_quant_stage
   import qnt_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cfg_load,
   input  logic [LANES-1:0][ACC_W-1:0] bias_in,
   input  logic [MULT_W-1:0]           mult_in,
   input  logic [SHIFT_W-1:0]          shift_in,
   input  logic [CNT_W-1:0]            col,
   input  logic                        clr_err,
   relu_quant_stage_if.slave           bus,
   output logic                        gap_err,
   output logic                        cfg_err
);
   // vld_pipe[k] is the valid of stage k; valid_in itself is stage 0
   logic [STAGES:1]              vld_pipe;
   logic [LANES-1:0][ACC_W-1:0]  bias_r;
   logic [MULT_W-1:0]            mult_r;
   logic [SHIFT_W-1:0]           shift_r;
   logic [CNT_W-1:0]             cnt;
   logic [LANES-1:0][OUT_W-1:0]  q_vec;
   logic                         idle, last_beat, gap_evt, cfg_evt;

   assign idle      = (vld_pipe == '0) && (cnt == '0);
   assign last_beat = (col != '0) && (cnt == col - 1'b1);
   assign gap_evt   = !bus.valid_out && (cnt != '0);
   assign cfg_evt   = cfg_load && !idle;

   assign bus.valid_out = vld_pipe[STAGES];
   assign bus.row_end   = vld_pipe[STAGES] && last_beat;
   assign bus.data_out  = q_vec;

   // valid shift register, fixed latency, no backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe <= '0;
      else        vld_pipe <= {vld_pipe[STAGES-1:1], bus.valid_in};
   end

   // config only changes with nothing in flight so every beat sees one set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bias_r  <= '0;
         mult_r  <= '0;
         shift_r <= '0;
      end else if (cfg_load && idle) begin
         bias_r  <= bias_in;
         mult_r  <= mult_in;
         shift_r <= shift_in;
      end
   end

   // beat counter: wraps on the last beat, saturates for col==0, clears on a gap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cnt <= '0;
      else if (bus.valid_out) begin
         if (last_beat)           cnt <= '0;
         else if (cnt != '1)      cnt <= cnt + 1'b1;
      end else if (cnt != '0)     cnt <= '0;
   end

   // sticky flags; a same-cycle error beats the clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_err <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         if (gap_evt)      gap_err <= 1'b1;
         else if (clr_err) gap_err <= 1'b0;
         if (cfg_evt)      cfg_err <= 1'b1;
         else if (clr_err) cfg_err <= 1'b0;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      quant_lane u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .en    ({vld_pipe[2:1], bus.valid_in}),
         .acc   (bus.data_in[i]),
         .bias  (bias_r[i]),
         .mult  (mult_r),
         .shift (shift_r),
         .q_out (q_vec[i])
      );
   end
endmodule

// File: tb/tb_relu_quant_stage.sv
// Randomised + directed bench for relu_quant_stage against an arithmetic reference model.
module tb_relu_quant_stage;
   import qnt_pkg::*;

   typedef logic [LANES-1:0][ACC_W-1:0] accv_t;
   typedef logic [LANES-1:0][OUT_W-1:0] outv_t;
   typedef struct { bit v; outv_t d; } beat_t;

   logic        clk = 1'b0, rst_n = 1'b0, cfg_load = 1'b0, clr_err = 1'b0;
   accv_t       bias_in = '0;
   logic [15:0] mult_in = '0, col = '0;
   logic [4:0]  shift_in = '0;
   logic        gap_err, cfg_err;

   relu_quant_stage_if bus();

   relu_quant_stage dut (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .bias_in(bias_in),
      .mult_in(mult_in), .shift_in(shift_in), .col(col), .clr_err(clr_err),
      .bus(bus), .gap_err(gap_err), .cfg_err(cfg_err));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;

   // reference model state
   accv_t       m_bias;
   logic [15:0] m_mult;
   logic [4:0]  m_shift;
   beat_t       mq[$];
   beat_t       m_out;
   int          m_cnt;
   bit          m_gap, m_cfg;

   function automatic logic [7:0] ref_lane(longint acc, longint bias, longint mult, int sh);
      longint p;
      p = (acc + bias) * mult;
`ifdef REQUANT_ROUND_EN
      if (sh > 0) p = p + (longint'(1) << (sh - 1));
`endif
      p = p >>> sh;
      if (p < 0)   return 8'd0;
      if (p > 255) return 8'd255;
      return p[7:0];
   endfunction

   function automatic outv_t ref_col(accv_t a);
      outv_t r;
      for (int i = 0; i < LANES; i++)
         r[i] = ref_lane(longint'($signed(a[i])), longint'($signed(m_bias[i])),
                         longint'(m_mult), int'(m_shift));
      return r;
   endfunction

   function automatic void mdl_reset();
      beat_t b0;
      b0.v = 1'b0; b0.d = '0;
      m_bias = '0; m_mult = '0; m_shift = '0;
      m_out = b0; mq.delete(); mq.push_back(b0); mq.push_back(b0);
      m_cnt = 0; m_gap = 1'b0; m_cfg = 1'b0;
   endfunction

   function automatic bit exp_re();
      return m_out.v && (col != 0) && (m_cnt == int'(col) - 1);
   endfunction

   // one clock edge of the spec-level behaviour
   function automatic void mdl_step();
      beat_t nb;
      bit idle, gap_evt, cfg_evt;
      idle    = !m_out.v && !mq[0].v && !mq[1].v && (m_cnt == 0);
      nb.v    = bus.valid_in;
      nb.d    = bus.valid_in ? ref_col(bus.data_in) : '0;
      gap_evt = !m_out.v && (m_cnt != 0);
      cfg_evt = cfg_load && !idle;
      if (m_out.v) begin
         if (exp_re())            m_cnt = 0;
         else if (m_cnt != 65535) m_cnt++;
      end else m_cnt = 0;
      m_gap = gap_evt || (m_gap && !clr_err);
      m_cfg = cfg_evt || (m_cfg && !clr_err);
      if (cfg_load && idle) begin
         m_bias = bias_in; m_mult = mult_in; m_shift = shift_in;
      end
      m_out = mq.pop_back();
      mq.push_front(nb);
   endfunction

   task automatic step();
      @(posedge clk);
      if (!rst_n) mdl_reset(); else mdl_step();
      #1;
   endtask

   task automatic drive(bit v, accv_t a);
      bus.valid_in = v;
      bus.data_in  = v ? a : '0;
   endtask

   task automatic do_cfg(accv_t b, logic [15:0] m, logic [4:0] s);
      bias_in = b; mult_in = m; shift_in = s; cfg_load = 1'b1;
      drive(1'b0, '0);
      step();
      cfg_load = 1'b0;
   endtask

   function automatic accv_t fill(logic [31:0] v);
      accv_t a;
      for (int i = 0; i < LANES; i++) a[i] = v;
      return a;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if ({bus.valid_out, bus.row_end, gap_err, cfg_err, bus.data_out} !== '0) begin
         n_bad++;
         $display("FAIL reset: got ctl %b data %h want all zero",
                  {bus.valid_out, bus.row_end, gap_err, cfg_err}, bus.data_out);
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      accv_t a; outv_t want; int beats = 0;
      for (int i = 0; i < LANES; i++) begin a[i] = i; want[i] = i; end
      col = 4;
      do_cfg(fill(0), 16'd1, 5'd0);
      for (int c = 0; c < 10; c++) begin
         drive(c < 4, a);
         @(negedge clk);
         n_cmp++;
         if ({bus.valid_out, bus.row_end, gap_err, cfg_err} !== {m_out.v, exp_re(), m_gap, m_cfg}) begin
            n_bad++; $display("FAIL basic_ctl: got %b want %b",
               {bus.valid_out, bus.row_end, gap_err, cfg_err}, {m_out.v, exp_re(), m_gap, m_cfg});
         end
         if (bus.valid_out) begin
            beats++;
            n_cmp++;
            if (bus.data_out !== want || bus.row_end !== (beats == 4) || (beats == 1 && c != 3)) begin
               n_bad++; $display("FAIL basic_beat%0d: cyc %0d row_end %b data %h want data %h cyc3 for beat1",
                  beats, c, bus.row_end, bus.data_out, want);
            end
         end
         step();
      end
      n_cmp++;
      if (beats != 4) begin n_bad++; $display("FAIL basic_count: got %0d beats want 4", beats); end
   endtask

   task automatic test_clamp();
      logic [31:0] accs [3]  = '{32'hFFFF_FFFB, 32'd300, 32'h7FFF_FFFF};
      logic [15:0] mults [3] = '{16'd1, 16'd1, 16'hFFFF};
      logic [4:0]  shs [3]   = '{5'd0, 5'd0, 5'd31};
      logic [7:0]  wants [3] = '{8'd0, 8'd255, 8'd255};
      col = 1;
      for (int k = 0; k < 3; k++) begin
         do_cfg(fill(0), mults[k], shs[k]);
         for (int c = 0; c < 5; c++) begin
            drive(c == 0, fill(accs[k]));
            @(negedge clk);
            n_cmp++;
            if ({bus.valid_out, bus.row_end, gap_err, cfg_err} !== {m_out.v, exp_re(), m_gap, m_cfg}) begin
               n_bad++; $display("FAIL clamp_ctl%0d: got %b want %b", k,
                  {bus.valid_out, bus.row_end, gap_err, cfg_err}, {m_out.v, exp_re(), m_gap, m_cfg});
            end
            if (bus.valid_out) begin
               n_cmp++;
               if (bus.data_out[0] !== wants[k] || bus.data_out[LANES-1] !== wants[k] || !bus.row_end) begin
                  n_bad++; $display("FAIL clamp%0d: got %0d/%0d row_end %b want %0d row_end 1", k,
                     bus.data_out[0], bus.data_out[LANES-1], bus.row_end, wants[k]);
               end
            end
            step();
         end
      end
   endtask

   task automatic test_bias_scale();
      logic [7:0] wants [2];
      int k = 0;
      wants[0] = 8'd60;
`ifdef REQUANT_ROUND_EN
      wants[1] = 8'd61;
`else
      wants[1] = 8'd60;
`endif
      col = 2;
      do_cfg(fill(32'hFFFF_FFEC), 16'd3, 5'd2);
      for (int c = 0; c < 6; c++) begin
         drive(c < 2, fill(c == 0 ? 32'd100 : 32'd101));
         @(negedge clk);
         if (bus.valid_out) begin
            n_cmp++;
            if (bus.data_out[0] !== wants[k] || bus.data_out !== m_out.d) begin
               n_bad++; $display("FAIL bias_scale%0d: got %0d (row %h) want %0d (row %h)", k,
                  bus.data_out[0], bus.data_out, wants[k], m_out.d);
            end
            k++;
         end
         step();
      end
   endtask

   task automatic test_rows();
      int beats = 0, res = 0;
      accv_t a;
      col = 6;
      do_cfg(fill(0), 16'd1, 5'd0);
      for (int c = 0; c < 16; c++) begin
         for (int i = 0; i < LANES; i++) a[i] = $urandom_range(0, 400) - 50;
         drive(c < 12, a);
         @(negedge clk);
         n_cmp++;
         if ({bus.valid_out, bus.row_end, gap_err, cfg_err} !== {m_out.v, exp_re(), m_gap, m_cfg}) begin
            n_bad++; $display("FAIL rows_ctl: got %b want %b",
               {bus.valid_out, bus.row_end, gap_err, cfg_err}, {m_out.v, exp_re(), m_gap, m_cfg});
         end
         if (bus.valid_out) begin
            beats++;
            n_cmp++;
            if (bus.data_out !== m_out.d || bus.row_end !== (beats == 6 || beats == 12)) begin
               n_bad++; $display("FAIL rows_beat%0d: data %h want %h row_end %b", beats,
                  bus.data_out, m_out.d, bus.row_end);
            end
            if (bus.row_end) res++;
         end
         step();
      end
      n_cmp++;
      if (res != 2 || gap_err !== 1'b0) begin
         n_bad++; $display("FAIL rows_total: row_end %0d gap_err %b want 2 and 0", res, gap_err);
      end
   endtask

   task automatic test_gap();
      int res = 0;
      col = 6;
      for (int c = 0; c < 8; c++) begin
         drive(c < 3, fill(32'd9));
         @(negedge clk);
         n_cmp++;
         if ({bus.valid_out, bus.row_end, gap_err, cfg_err} !== {m_out.v, exp_re(), m_gap, m_cfg}) begin
            n_bad++; $display("FAIL gap_ctl: got %b want %b",
               {bus.valid_out, bus.row_end, gap_err, cfg_err}, {m_out.v, exp_re(), m_gap, m_cfg});
         end
         if (bus.row_end) res++;
         step();
      end
      n_cmp++;
      if (gap_err !== 1'b1 || res != 0) begin
         n_bad++; $display("FAIL gap_partial: gap_err %b row_end %0d want 1 and 0", gap_err, res);
      end
      for (int c = 0; c < 10; c++) begin
         drive(c < 6, fill(32'd9));
         @(negedge clk);
         if (bus.row_end) res++;
         step();
      end
      n_cmp++;
      if (res != 1 || gap_err !== 1'b1) begin
         n_bad++; $display("FAIL gap_fullrow: row_end %0d gap_err %b want 1 and 1", res, gap_err);
      end
      clr_err = 1'b1; step(); clr_err = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (gap_err !== 1'b0) begin n_bad++; $display("FAIL gap_clear: got %b want 0", gap_err); end
      step();
   endtask

   task automatic test_cfg_reset();
      int res = 0, beats = 0;
      col = 6;
      do_cfg(fill(0), 16'd1, 5'd0);
      for (int c = 0; c < 12; c++) begin
         drive(c < 6, fill(32'd10));
         cfg_load = (c == 2); mult_in = 16'd2;
         @(negedge clk);
         n_cmp++;
         if ({bus.valid_out, bus.row_end, gap_err, cfg_err} !== {m_out.v, exp_re(), m_gap, m_cfg}) begin
            n_bad++; $display("FAIL cfg_ctl: got %b want %b",
               {bus.valid_out, bus.row_end, gap_err, cfg_err}, {m_out.v, exp_re(), m_gap, m_cfg});
         end
         if (bus.valid_out) begin
            n_cmp++;
            if (bus.data_out[0] !== 8'd10) begin
               n_bad++; $display("FAIL cfg_oldmult: got %0d want 10", bus.data_out[0]);
            end
         end
         step();
      end
      cfg_load = 1'b0;
      n_cmp++;
      if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL cfg_err_set: got %b want 1", cfg_err); end
      clr_err = 1'b1; step(); clr_err = 1'b0;
      // partial row then async reset with beats in flight
      for (int c = 0; c < 5; c++) begin
         drive(1'b1, fill(32'd7));
         cfg_load = (c == 1);
         step();
      end
      cfg_load = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.valid_out, bus.row_end, gap_err, cfg_err, bus.data_out} !== '0) begin
         n_bad++; $display("FAIL async_reset: ctl %b data %h want all zero",
            {bus.valid_out, bus.row_end, gap_err, cfg_err}, bus.data_out);
      end
      drive(1'b0, '0);
      step();
      rst_n = 1'b1;
      do_cfg(fill(0), 16'd1, 5'd0);
      for (int c = 0; c < 10; c++) begin
         drive(c < 6, fill(32'd3));
         @(negedge clk);
         n_cmp++;
         if ({bus.valid_out, bus.row_end, gap_err, cfg_err} !== {m_out.v, exp_re(), m_gap, m_cfg}) begin
            n_bad++; $display("FAIL post_reset_ctl: got %b want %b",
               {bus.valid_out, bus.row_end, gap_err, cfg_err}, {m_out.v, exp_re(), m_gap, m_cfg});
         end
         if (bus.valid_out) beats++;
         if (bus.row_end) begin
            res++;
            n_cmp++;
            if (beats != 6) begin n_bad++; $display("FAIL post_reset_beat: row_end at %0d want 6", beats); end
         end
         step();
      end
      n_cmp++;
      if (res != 1 || gap_err !== 1'b0) begin
         n_bad++; $display("FAIL post_reset_row: row_end %0d gap_err %b want 1 and 0", res, gap_err);
      end
   endtask

   task automatic test_back_to_back();
      accv_t a, b;
      bit v;
      for (int r = 0; r < 3; r++) begin
         col = 16'($urandom_range(0, 5));
         for (int i = 0; i < LANES; i++) b[i] = 32'($urandom_range(0, 2097152)) - 32'd1048576;
         do_cfg(b, 16'($urandom_range(0, 65535)), 5'($urandom_range(0, 31)));
         for (int c = 0; c < 305; c++) begin
            v = (c < 300) && ($urandom_range(0, 99) < 85);
            for (int i = 0; i < LANES; i++) a[i] = 32'($signed($urandom) >>> $urandom_range(4, 31));
            drive(v, a);
            clr_err  = ($urandom_range(0, 99) < 4);
            cfg_load = !v && ($urandom_range(0, 99) < 3);
            if (cfg_load) begin
               for (int i = 0; i < LANES; i++) b[i] = 32'($urandom_range(0, 2097152)) - 32'd1048576;
               bias_in = b; mult_in = 16'($urandom_range(0, 65535)); shift_in = 5'($urandom_range(0, 31));
            end
            @(negedge clk);
            n_cmp++;
            if ({bus.valid_out, bus.row_end, gap_err, cfg_err} !== {m_out.v, exp_re(), m_gap, m_cfg}) begin
               n_bad++; $display("FAIL b2b_ctl r%0d c%0d: got %b want %b", r, c,
                  {bus.valid_out, bus.row_end, gap_err, cfg_err}, {m_out.v, exp_re(), m_gap, m_cfg});
            end
            if (m_out.v) begin
               n_cmp++;
               if (bus.data_out !== m_out.d) begin
                  n_bad++; $display("FAIL b2b_data r%0d c%0d: got %h want %h", r, c, bus.data_out, m_out.d);
               end
            end
            step();
         end
         clr_err = 1'b0; cfg_load = 1'b0;
      end
   endtask

   initial begin
      mdl_reset();
      drive(1'b0, '0);
      test_reset();
      test_basic();
      test_clamp();
      test_bias_scale();
      test_rows();
      test_gap();
      test_cfg_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
